// File: rtl/sixteen_bit_down_counter_pkg.sv
// Shared constants and state type for the 16-bit down-counter.
package dec_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] ALL_ONES = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sixteen_bit_down_counter_if.sv
// Control/status bundle for the down-counter.
// The master drives load, start, en and dec. The slave (the counter) returns
// count, busy, done and underflow.
interface sixteen_bit_down_counter_if;
    import dec_pkg::*;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic             dec;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             underflow;

    modport master (
        output load, load_val, start, en, dec,
        input  count, busy, done, underflow
    );

    modport slave (
        input  load, load_val, start, en, dec,
        output count, busy, done, underflow
    );
endinterface

// File: rtl/sixteen_bit_down_counter_dec.sv
// Gate-level ripple decrementer: out = in + 16'hFFFF, built from full_add cells.
// borrow is the inverted final carry. It is high only when in == 0.

// One-bit full adder cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module sixteen_bit_decrementer
    import dec_pkg::*;
(
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);
    // carry[0] is the chain input; carry[gi+1] leaves bit gi
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    // Each cell adds a constant 1 on b, rippling carry strictly from bit gi-1
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            full_add u_fa (
                .a    (in[gi]),
                .b    (1'b1),
                .cin  (carry[gi]),
                .s    (out[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign borrow = ~carry[WIDTH];
endmodule

// File: rtl/sixteen_bit_down_counter.sv
// Loadable 16-bit down-counter with a start/run/done handshake.
// Compile-time option DEC_SATURATE_EN: when defined, a single-step dec at
// count 0 holds the count at 0 instead of wrapping to 16'hFFFF. underflow
// still pulses in both builds.
module sixteen_bit_down_counter
    import dec_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    sixteen_bit_down_counter_if.slave      bus
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             underflow_reg, underflow_next;
    logic [WIDTH-1:0] dec_val;
    logic             dec_borrow;

    sixteen_bit_decrementer u_dec (
        .in     (count_reg),
        .out    (dec_val),
        .borrow (dec_borrow)
    );

    // State, count and underflow registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    // Next state / next count: load beats start, and start beats dec
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        underflow_next = 1'b0;
        if (bus.load) begin
            count_next = bus.load_val;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_next = (count_reg == '0) ? DONE : RUN;
                    end else if (bus.dec) begin
                        underflow_next = dec_borrow;
`ifdef DEC_SATURATE_EN
                        count_next = dec_borrow ? count_reg : dec_val;
`else
                        count_next = dec_val;
`endif
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        // Never count below zero while running
                        if (count_reg == '0) begin
                            state_next = DONE;
                        end else begin
                            count_next = dec_val;
                            if (count_reg == WIDTH'(1)) begin
                                state_next = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.count     = count_reg;
    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == DONE);
    assign bus.underflow = underflow_reg;

endmodule

// File: tb/tb_sixteen_bit_down_counter.sv
// Self-checking bench for sixteen_bit_down_counter.
// It runs directed scenarios and then randomized traffic. Each cycle is
// compared with a behavioural model that keeps the count as an integer.
module tb_sixteen_bit_down_counter;
    logic clk = 1'b0;
    logic rst_n;

    sixteen_bit_down_counter_if bus ();

    sixteen_bit_down_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: plain integer count plus "running" and "finished" flags
    int m_count   = 0;
    bit m_running = 0;
    bit m_done    = 0;
    bit m_uf      = 0;

    // Single comparison point: counts every check and reports a mismatch
    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_edge(input bit r, input bit l, input int lv,
                              input bit s, input bit e, input bit d);
        bit was_done;
        was_done = m_done;
        m_uf   = 0;
        m_done = 0;
        if (!r) begin
            m_count   = 0;
            m_running = 0;
        end else if (l) begin
            m_count   = lv;
            m_running = 0;
        end else if (was_done) begin
            m_running = 0;
        end else if (m_running) begin
            if (e) begin
                if (m_count > 0) m_count = m_count - 1;
                if (m_count == 0) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end else if (s) begin
            if (m_count == 0) m_done = 1;
            else              m_running = 1;
        end else if (d) begin
            if (m_count == 0) begin
                m_uf = 1;
`ifdef DEC_SATURATE_EN
                m_count = 0;
`else
                m_count = 65535;
`endif
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    // Apply one cycle of inputs, then compare all outputs 1 time unit after the edge
    task automatic step(input bit r, input bit l, input logic [15:0] lv,
                        input bit s, input bit e, input bit d);
        rst_n        = r;
        bus.load     = l;
        bus.load_val = lv;
        bus.start    = s;
        bus.en       = e;
        bus.dec      = d;
        @(posedge clk);
        model_edge(r, l, int'(lv), s, e, d);
        #1;
        check_val("count",     bus.count,            16'(m_count));
        check_val("busy",      16'(bus.busy),        16'(m_running));
        check_val("done",      16'(bus.done),        16'(m_done));
        check_val("underflow", 16'(bus.underflow),   16'(m_uf));
        if (bus.done && bus.underflow) check_val("done_uf_excl", 16'd1, 16'd0);
    endtask

    logic [15:0] exp_wrap;

    initial begin
`ifdef DEC_SATURATE_EN
        exp_wrap = 16'h0000;
`else
        exp_wrap = 16'hFFFF;
`endif
        rst_n = 1'b0;
        bus.load = 0; bus.load_val = 0; bus.start = 0; bus.en = 0; bus.dec = 0;

        // Reset wins over load and start
        step(0, 1, 16'h1234, 1, 0, 0);
        step(0, 1, 16'h1234, 1, 0, 0);
        check_val("rst_count", bus.count, 16'h0000);
        check_val("rst_busy",  16'(bus.busy), 16'd0);
        $display("reset: count=0x%04h busy=%0d done=%0d uf=%0d", bus.count, bus.busy, bus.done, bus.underflow);

        // Countdown from 5 with en held high
        step(1, 1, 16'h0005, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 1, 0);
        check_val("t2_busy", 16'(bus.busy), 16'd1);
        for (int i = 4; i >= 0; i--) begin
            step(1, 0, 16'h0000, 0, 1, 0);
            check_val("t2_count", bus.count, 16'(i));
            $display("countdown: count=0x%04h busy=%0d done=%0d", bus.count, bus.busy, bus.done);
        end
        check_val("t2_done", 16'(bus.done), 16'd1);
        step(1, 0, 16'h0000, 0, 1, 0);
        check_val("t2_idle", 16'(bus.busy), 16'd0);

        // en gating while running
        step(1, 1, 16'h0010, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0);
        step(1, 0, 16'h0000, 0, 1, 0); check_val("t3_c0", bus.count, 16'h000F);
        step(1, 0, 16'h0000, 0, 0, 0); check_val("t3_c1", bus.count, 16'h000F);
        step(1, 0, 16'h0000, 0, 0, 0); check_val("t3_c2", bus.count, 16'h000F);
        step(1, 0, 16'h0000, 0, 1, 0); check_val("t3_c3", bus.count, 16'h000E);
        check_val("t3_busy", 16'(bus.busy), 16'd1);
        $display("en gating: count=0x%04h busy=%0d", bus.count, bus.busy);

        // Single-step dec at zero
        step(1, 1, 16'h0000, 0, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 1);
        check_val("t4_count", bus.count, exp_wrap);
        check_val("t4_uf",    16'(bus.underflow), 16'd1);
        step(1, 0, 16'h0000, 0, 0, 0);
        check_val("t4_uf_clr", 16'(bus.underflow), 16'd0);
        $display("dec at zero: count=0x%04h", bus.count);

        // Borrow propagation through the ripple chain
        step(1, 1, 16'h8000, 0, 0, 0); step(1, 0, 16'h0000, 0, 0, 1);
        check_val("t5_8000", bus.count, 16'h7FFF);
        step(1, 1, 16'h0100, 0, 0, 0); step(1, 0, 16'h0000, 0, 0, 1);
        check_val("t5_0100", bus.count, 16'h00FF);
        step(1, 1, 16'h0001, 0, 0, 1); step(1, 0, 16'h0000, 0, 0, 1);
        check_val("t5_0001", bus.count, 16'h0000);
        check_val("t5_no_uf", 16'(bus.underflow), 16'd0);
        $display("borrow chain: last count=0x%04h", bus.count);

        // Load overrides RUN, and start at zero goes straight to done
        step(1, 1, 16'h1234, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0);
        step(1, 1, 16'hABCD, 0, 1, 0);
        check_val("t6_load", bus.count, 16'hABCD);
        check_val("t6_busy", 16'(bus.busy), 16'd0);
        step(1, 1, 16'h0000, 0, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 1);
        check_val("t6_done",  16'(bus.done), 16'd1);
        check_val("t6_count", bus.count, 16'h0000);
        $display("load in run / start at zero: count=0x%04h done=%0d", bus.count, bus.done);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, l, s, e, d;
            logic [15:0] lv;
            r  = ($urandom_range(99) >= 2);
            l  = ($urandom_range(99) < 6);
            lv = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(12));
            s  = ($urandom_range(99) < 25);
            e  = ($urandom_range(99) < 70);
            d  = ($urandom_range(99) < 30);
            step(r, l, lv, s, e, d);
        end
        $display("random: 3000 cycles, final count=0x%04h", bus.count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
